// File: rtl/uart_tx_frame_ctrl.sv
// rtl/uart_tx_frame_ctrl.sv - UART transmit frame controller (start/data/parity/stop sequencing)
module uart_tx_frame_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] P_DATA,
    input  logic             DATA_VALID,
    input  logic             PAR_EN,
    input  logic             PAR_TYP,
    input  logic             ser_data,
    input  logic             ser_done,
    output logic             ser_en,
    output logic             TX_OUT,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t state;
    state_t next_state;

    // Frame options captured at acceptance; the parity bit is the data
    // parity folded with the parity type, so both halves are kept.
    logic data_par;
    logic par_en_q;
    logic par_typ_q;
    logic par_bit;
    logic accept;

    // A new frame is taken from IDLE or straight out of STOP (back-to-back).
    assign accept  = DATA_VALID && ((state == IDLE) || (state == STOP));
    assign par_bit = data_par ^ par_typ_q;

    // State register; reset aborts any frame in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Latch parity and options only when a frame is accepted, so mid-frame
    // input changes cannot disturb the frame being sent.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            data_par  <= 1'b0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
        end else if (accept) begin
            data_par  <= ^P_DATA;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
        end
    end

    // Next-state logic; ser_done is only meaningful while in DATA.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = DATA_VALID ? START : IDLE;
            START:   next_state = DATA;
            DATA:    begin
                if (ser_done) begin
                    next_state = par_en_q ? PARITY : STOP;
                end
            end
            PARITY:  next_state = STOP;
            STOP:    next_state = DATA_VALID ? START : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode from the registered state (and serial data in DATA).
    always_comb begin
        ser_en = 1'b0;
        TX_OUT = 1'b1;
        busy   = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
            end
            START: begin
                ser_en = 1'b1;
                TX_OUT = 1'b0;
            end
            DATA: begin
                ser_en = 1'b1;
                TX_OUT = ser_data;
            end
            PARITY: begin
                TX_OUT = par_bit;
            end
            STOP: begin
                TX_OUT = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// tb/tb_uart_tx_frame_ctrl.sv - directed self-checking bench for uart_tx_frame_ctrl
module tb_uart_tx_frame_ctrl;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       ser_data;
    logic       ser_done;
    logic       ser_en;
    logic       TX_OUT;
    logic       busy;

    int checks;
    int failures;

    // Serializer model: loads while ser_en is low, then presents one bit per edge LSB first.
    logic [7:0] sreg;
    logic [3:0] cnt;
    logic       model_done;
    logic       inj_done;

    uart_tx_frame_ctrl #(.WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .ser_data   (ser_data),
        .ser_done   (ser_done),
        .ser_en     (ser_en),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign ser_done = model_done | inj_done;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            sreg       <= 8'h00;
            cnt        <= 4'd0;
            model_done <= 1'b0;
            ser_data   <= 1'b0;
        end else if (!ser_en) begin
            sreg       <= P_DATA;
            cnt        <= 4'd0;
            model_done <= 1'b0;
            ser_data   <= 1'b0;
        end else begin
            if (cnt < 4'd8) ser_data <= sreg[cnt[2:0]];
            model_done <= (cnt == 4'd7);
            if (cnt < 4'd15) cnt <= cnt + 4'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_tx"}, {31'd0, TX_OUT}, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_seren"}, {31'd0, ser_en}, 32'd0);
    endtask

    // Send one frame and check every bit. Called at a negedge with the DUT idle.
    // mid_change: scramble P_DATA/PAR_EN/PAR_TYP and raise DATA_VALID during DATA.
    // inj_par: pulse ser_done during the PARITY cycle.
    task automatic run_frame(input string tag, input logic [7:0] d, input logic pen,
                             input logic ptyp, input logic mid_change, input logic inj_par);
        logic exp_bits [0:10];
        int   len;
        len = 10 + (pen ? 1 : 0);
        exp_bits[0] = 1'b0;
        for (int b = 0; b < 8; b++) exp_bits[1 + b] = d[b];
        exp_bits[9] = pen ? ((^d) ^ ptyp) : 1'b1;
        exp_bits[10] = 1'b1;
        P_DATA = d;
        PAR_EN = pen;
        PAR_TYP = ptyp;
        DATA_VALID = 1'b1;
        @(negedge CLK);
        DATA_VALID = 1'b0;
        for (int i = 0; i < len; i++) begin
            chk($sformatf("%s_tx%0d", tag, i), {31'd0, TX_OUT}, {31'd0, exp_bits[i]});
            chk($sformatf("%s_busy%0d", tag, i), {31'd0, busy}, 32'd1);
            chk($sformatf("%s_seren%0d", tag, i), {31'd0, ser_en}, {31'd0, (i <= 8)});
            if (mid_change && i == 3) begin
                P_DATA = 8'h00;
                PAR_EN = ~pen;
                PAR_TYP = ~ptyp;
                DATA_VALID = 1'b1;
            end
            if (mid_change && i == len - 2) DATA_VALID = 1'b0;
            if (inj_par && pen && i == 9) inj_done = 1'b1;
            @(negedge CLK);
            inj_done = 1'b0;
        end
        chk_idle({tag, "_end"});
    endtask

    initial begin
        logic exp_a5 [0:9];
        logic exp_b2b [0:19];
        logic [7:0] d1;
        logic [7:0] d2;
        checks = 0;
        failures = 0;
        RST = 1'b1;
        P_DATA = 8'h00;
        DATA_VALID = 1'b0;
        PAR_EN = 1'b0;
        PAR_TYP = 1'b0;
        inj_done = 1'b0;

        // Reset state
        #2;
        chk_idle("reset");
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        chk_idle("post_reset");

        // 0xA5, no parity: hand-computed line sequence
        exp_a5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        P_DATA = 8'hA5;
        DATA_VALID = 1'b1;
        @(negedge CLK);
        DATA_VALID = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("a5_np_tx%0d", i), {31'd0, TX_OUT}, {31'd0, exp_a5[i]});
            chk($sformatf("a5_np_busy%0d", i), {31'd0, busy}, 32'd1);
            @(negedge CLK);
        end
        chk_idle("a5_np_end");

        // Parity frames: 0xA5 even -> 0, odd -> 1; 0x07 even -> 1 with mid-frame changes
        run_frame("a5_even", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        run_frame("a5_odd", 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
        run_frame("07_even_mid", 8'h07, 1'b1, 1'b0, 1'b1, 1'b0);

        // ser_done in IDLE: no effect
        inj_done = 1'b1;
        @(negedge CLK);
        inj_done = 1'b0;
        chk_idle("inj_idle");
        @(negedge CLK);
        chk_idle("inj_idle2");

        // ser_done in PARITY: still goes to STOP after one parity cycle
        run_frame("inj_par", 8'h81, 1'b1, 1'b1, 1'b0, 1'b1);

        // Back-to-back frames with DATA_VALID held high: 0x55 then 0x0F
        d1 = 8'h55;
        d2 = 8'h0F;
        exp_b2b[0] = 1'b0;
        exp_b2b[10] = 1'b0;
        for (int b = 0; b < 8; b++) begin
            exp_b2b[1 + b] = d1[b];
            exp_b2b[11 + b] = d2[b];
        end
        exp_b2b[9] = 1'b1;
        exp_b2b[19] = 1'b1;
        P_DATA = d1;
        PAR_EN = 1'b0;
        PAR_TYP = 1'b0;
        DATA_VALID = 1'b1;
        @(negedge CLK);
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("b2b_tx%0d", i), {31'd0, TX_OUT}, {31'd0, exp_b2b[i]});
            chk($sformatf("b2b_busy%0d", i), {31'd0, busy}, 32'd1);
            if (i == 0) P_DATA = d2;
            if (i == 10) DATA_VALID = 1'b0;
            @(negedge CLK);
        end
        chk_idle("b2b_end");

        // Reset in the 4th DATA cycle aborts immediately
        P_DATA = 8'hA5;
        PAR_EN = 1'b1;
        DATA_VALID = 1'b1;
        @(negedge CLK);
        DATA_VALID = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge CLK);
        chk("rst_mid_pre_busy", {31'd0, busy}, 32'd1);
        chk("rst_mid_pre_tx", {31'd0, TX_OUT}, {31'd0, 1'b0});
        RST = 1'b1;
        #1;
        chk_idle("rst_mid");
        @(negedge CLK);
        chk_idle("rst_mid_held");
        RST = 1'b0;

        // Full frame right after reset release
        run_frame("3c_after_rst", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame("3c_par_after", 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame_ctrl.md
UART_TX_FRAME_CTRL -- requirements
Module: uart_tx_frame_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, number of data bits per frame.
REQ-002 Clocking: one clock; reset is asynchronous and active-high.
REQ-003 CLK  in  1  bit clock; one UART bit period per cycle.
REQ-004 RST  in  1  asynchronous active-high reset.
REQ-005 P_DATA  in  WIDTH  parallel frame data; read by the serializer and by the parity latch.
REQ-006 DATA_VALID  in  1  request to send P_DATA; sampled only when accepting.
REQ-007 PAR_EN  in  1  1 = insert parity bit.
REQ-008 PAR_TYP  in  1  0 = even parity, 1 = odd parity.
REQ-009 ser_data  in  1  serial data bit from the serializer.
REQ-010 ser_done  in  1  serializer last-bit flag.
REQ-011 ser_en  out  1  serializer enable; low makes the serializer load P_DATA.
REQ-012 TX_OUT  out  1  UART line; idle level 1.
REQ-013 busy  out  1  frame in progress.

Function
REQ-014 The serializer contract SHALL be as follows:
- While ser_en is low, the serializer loads P_DATA every edge.
- While ser_en is high, each edge presents the next bit on ser_data, LSB first.
- ser_done is high during the cycle in which the last bit is presented.
REQ-015 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP, with a registered state and binary encoding.
REQ-016 IDLE: on DATA_VALID=1, the next state SHALL be START, and PAR_EN/PAR_TYP SHALL be latched.
- The parity bit SHALL be latched as ^P_DATA XOR PAR_TYP.
REQ-017 START SHALL last exactly 1 cycle, with next state DATA.
REQ-018 DATA SHALL stay in place while ser_done=0.
- On ser_done=1, the next state SHALL be PARITY if latched PAR_EN=1, otherwise STOP.
REQ-019 PARITY SHALL last exactly 1 cycle, with next state STOP.
REQ-020 STOP SHALL last 1 cycle.
- If DATA_VALID=1, the block SHALL re-latch as in IDLE and go to START (back-to-back frames, no idle gap).
- Otherwise the next state SHALL be IDLE.
REQ-021 ser_en SHALL be 1 in START and DATA, and 0 in IDLE, PARITY and STOP; it is decoded combinationally from the state only.
REQ-022 TX_OUT SHALL be decoded combinationally from the registered state and the registered inputs:
- IDLE = 1
- START = 0
- DATA = ser_data
- PARITY = latched parity bit
- STOP = 1
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 DATA_VALID SHALL be ignored in START, DATA and PARITY; the latched values SHALL be unaffected by P_DATA, PAR_EN and PAR_TYP changes mid-frame.
REQ-025 Frame length SHALL be 2+WIDTH+PAR_EN cycles, with the first TX_OUT=0 in the cycle after DATA_VALID is sampled high.
REQ-026 Any ser_done pulse outside DATA SHALL have no effect.
REQ-027 If ser_done never asserts, the block SHALL remain in DATA; no timeout is provided.

Reset
REQ-028 RST=1 SHALL asynchronously force state=IDLE and clear the latched parity bit, PAR_EN and PAR_TYP to 0; outputs SHALL be TX_OUT=1, busy=0, ser_en=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately, with TX_OUT=1 in the same cycle.
- No partial parity or stop bit SHALL be emitted.
REQ-030 After RST deasserts, the first DATA_VALID SHALL be accepted on the next edge.

Verification
REQ-031 WIDTH=8, P_DATA=0xA5, PAR_EN=0, one DATA_VALID pulse -> TX_OUT = 0,1,0,1,0,0,1,0,1,1 over 10 cycles; busy high for those 10 cycles.
REQ-032 P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 -> parity bit 0, 11-cycle frame.
- With PAR_TYP=1 -> parity bit 1.
REQ-033 P_DATA=0x07, PAR_EN=1, PAR_TYP=0 -> parity bit 1.
- Change P_DATA to 0x00 during DATA -> frame and parity unchanged.
REQ-034 DATA_VALID held high continuously with 0x55 then 0x0F -> STOP of frame 1 is followed directly by START of frame 2; busy never drops between the frames.
REQ-035 Assert RST in the 4th DATA cycle -> TX_OUT=1, busy=0, ser_en=0 immediately.
- Release RST and send 0x3C -> correct full frame.
REQ-036 Inject ser_done=1 in IDLE and PARITY -> no state change; TX_OUT stays at the expected level.
